branch_outcome_tracker: RTL and testbench
=========================================

BRANCH_OUTCOME_TRACKER -- requirements
Module: branch_outcome_tracker

Interface
REQ-001 SHALL have parameter CPHT_INDEX_BITS, default 10, meaning chooser-table index width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning in-flight branch entries (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port push_valid  in  1  Fetch issues a predicted branch.
REQ-006 SHALL have port push_ready  out  1  queue accepts a push (not full).
REQ-007 SHALL have port push_index  in  CPHT_INDEX_BITS  chooser index used at Fetch.
REQ-008 SHALL have port push_local_pred  in  1  local predictor direction (1 = taken).
REQ-009 SHALL have port push_global_pred  in  1  global predictor direction (1 = taken).
REQ-010 SHALL have port push_choice  in  1  chooser selection at Fetch (0 global, 1 local).
REQ-011 SHALL have port resolve_valid  in  1  Execute resolves the oldest in-flight branch.
REQ-012 SHALL have port resolve_taken  in  1  actual branch outcome.
REQ-013 SHALL have port flush  in  1  discard all in-flight entries.
REQ-014 SHALL have port upd_valid  out  1  chooser training strobe (drives chooser branch-in-Execute input).
REQ-015 SHALL have port upd_index  out  CPHT_INDEX_BITS  chooser index to train.
REQ-016 SHALL have port upd_local_correct  out  1  local prediction matched outcome.
REQ-017 SHALL have port upd_global_correct  out  1  global prediction matched outcome.
REQ-018 SHALL have port mispredict  out  1  selected final prediction differed from outcome.
REQ-019 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-020 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-021 SHALL store each accepted push (push_valid && push_ready) as {index, local_pred, global_pred, choice} at the tail, FIFO order.
REQ-022 SHALL use read/write pointers with one extra wrap bit; full = same low bits, differing wrap bit; empty = pointers equal.
REQ-023 SHALL drive push_ready = !full combinationally from registered state only; simultaneous resolve does not open a slot that cycle.
REQ-024 SHALL, on resolve_valid with queue non-empty and no flush, pop the head entry and register outputs on that edge (latency 1 cycle: upd_* valid the cycle after the resolve cycle).
REQ-025 SHALL compute upd_local_correct = (local_pred == resolve_taken), upd_global_correct = (global_pred == resolve_taken).
REQ-026 SHALL compute mispredict = ((choice ? local_pred : global_pred) != resolve_taken), qualified by upd_valid (0 when upd_valid = 0).
REQ-027 SHALL hold upd_valid high exactly one cycle per resolved entry; upd_index/correct bits hold last values when upd_valid = 0.
REQ-028 SHALL allow push and resolve in the same cycle when 0 < count < DEPTH; count unchanged, both pointers advance.
REQ-029 SHALL ignore resolve_valid when empty (no pop, upd_valid = 0 next cycle) and set err.
REQ-030 SHALL ignore push_valid when full (no write) and set err.
REQ-031 SHALL, on flush, reset both pointers to 0 (count = 0) at that edge; flush overrides same-cycle push and resolve, producing no upd_valid; an upd_valid already registered from the prior cycle still completes.
REQ-032 SHALL keep err set until reset.
REQ-033 SHALL wrap pointers modulo 2*DEPTH without loss of ordering.

Reset
REQ-034 SHALL, while rst_n = 0, asynchronously force pointers = 0, count = 0, upd_valid = 0, upd_index = 0, upd_local_correct = 0, upd_global_correct = 0, mispredict = 0, err = 0; push_ready = 1 after reset.
REQ-035 SHALL NOT reset storage array contents; reset mid-operation discards all in-flight entries.

Verification
REQ-036 SHALL verify: push {idx=0x155, local=1, global=0, choice=0}, next cycle resolve taken=1 -> following cycle upd_valid=1, upd_index=0x155, local_correct=1, global_correct=0, mispredict=1.
REQ-037 SHALL verify: 4 pushes (DEPTH=4) -> push_ready=0, count=4; 5th push dropped, err=1; 4 resolves return indices in push order.
REQ-038 SHALL verify: count=2, simultaneous push and resolve -> count stays 2, one upd_valid pulse for oldest entry.
REQ-039 SHALL verify: count=3, flush with resolve_valid=1 -> count=0 next cycle, no upd_valid, push_ready=1.
REQ-040 SHALL verify: resolve on empty -> upd_valid stays 0, err=1; rst_n low mid-stream -> all outputs zero immediately.
REQ-041 SHALL verify: 10 push/resolve cycles with DEPTH=4 -> pointer wrap, outputs still in order, err=0.

Source files
------------

// File: rtl/branch_outcome_tracker.sv
// In-flight branch queue between Fetch and Execute: remembers each prediction's chooser
// inputs and, when the oldest branch resolves, emits one registered training pulse.
module branch_outcome_tracker #(
  parameter int CPHT_INDEX_BITS = 10,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [CPHT_INDEX_BITS-1:0] push_index,
  input  logic                       push_local_pred,
  input  logic                       push_global_pred,
  input  logic                       push_choice,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic                       upd_valid,
  output logic [CPHT_INDEX_BITS-1:0] upd_index,
  output logic                       upd_local_correct,
  output logic                       upd_global_correct,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = CPHT_INDEX_BITS + 3;

  logic [PTR_W:0]       wr_ptr;
  logic [PTR_W:0]       rd_ptr;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic                 full;
  logic                 empty;
  logic                 do_push;
  logic                 do_pop;
  logic [ENTRY_W-1:0]   head;
  logic [CPHT_INDEX_BITS-1:0] head_index;
  logic                 head_local;
  logic                 head_global;
  logic                 head_choice;
  logic                 head_final;

  // The extra wrap bit distinguishes full from empty when the low bits coincide.
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign push_ready = !full;

  assign do_push = push_valid && !full && !flush;
  assign do_pop  = resolve_valid && !empty && !flush;

  assign head = mem[rd_ptr[PTR_W-1:0]];
  assign {head_index, head_local, head_global, head_choice} = head;
  assign head_final = head_choice ? head_local : head_global;

  // Storage is deliberately left without reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[PTR_W-1:0]] <= {push_index, push_local_pred, push_global_pred, push_choice};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      upd_valid          <= 1'b0;
      upd_index          <= '0;
      upd_local_correct  <= 1'b0;
      upd_global_correct <= 1'b0;
      mispredict         <= 1'b0;
      err                <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      upd_valid  <= do_pop;
      mispredict <= do_pop && (head_final != resolve_taken);
      if (do_pop) begin
        upd_index          <= head_index;
        upd_local_correct  <= (head_local == resolve_taken);
        upd_global_correct <= (head_global == resolve_taken);
      end

      if ((push_valid && full) || (resolve_valid && empty)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Directed-vector bench for branch_outcome_tracker with hand-computed expectations.
module tb_branch_outcome_tracker;

  logic       clk;
  logic       rst_n;
  logic       push_valid;
  logic       push_ready;
  logic [9:0] push_index;
  logic       push_local_pred;
  logic       push_global_pred;
  logic       push_choice;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       flush;
  logic       upd_valid;
  logic [9:0] upd_index;
  logic       upd_local_correct;
  logic       upd_global_correct;
  logic       mispredict;
  logic [2:0] count;
  logic       err;

  int num_compared;
  int num_mismatched;

  branch_outcome_tracker #(.CPHT_INDEX_BITS(10), .DEPTH(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .push_valid         (push_valid),
    .push_ready         (push_ready),
    .push_index         (push_index),
    .push_local_pred    (push_local_pred),
    .push_global_pred   (push_global_pred),
    .push_choice        (push_choice),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .flush              (flush),
    .upd_valid          (upd_valid),
    .upd_index          (upd_index),
    .upd_local_correct  (upd_local_correct),
    .upd_global_correct (upd_global_correct),
    .mispredict         (mispredict),
    .count              (count),
    .err                (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drives inputs, lets one rising edge pass, returns at the next negedge.
  task automatic applyStimulus(input logic pv, input logic [9:0] idx, input logic lp,
                               input logic gp, input logic ch, input logic rv,
                               input logic tk, input logic fl);
    push_valid       = pv;
    push_index       = idx;
    push_local_pred  = lp;
    push_global_pred = gp;
    push_choice      = ch;
    resolve_valid    = rv;
    resolve_taken    = tk;
    flush            = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Fill-test entries: index, local, global, choice, outcome, expected lc/gc/mp
  logic [9:0] fill_idx [4] = '{10'h011, 10'h022, 10'h033, 10'h044};
  logic       fill_lp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       fill_gp  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic       fill_ch  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       fill_tk  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic       fill_lc  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       fill_gc  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic       fill_mp  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    rst_n            = 1'b0;
    push_valid       = 1'b0;
    push_index       = '0;
    push_local_pred  = 1'b0;
    push_global_pred = 1'b0;
    push_choice      = 1'b0;
    resolve_valid    = 1'b0;
    resolve_taken    = 1'b0;
    flush            = 1'b0;

    @(negedge clk);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_upd_valid", 32'(upd_valid), 32'd0);
    checkOutput("rst_push_ready", 32'(push_ready), 32'd1);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_mispredict", 32'(mispredict), 32'd0);
    rst_n = 1'b1;

    // Basic push then resolve, one-cycle latency
    applyStimulus(1'b1, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("basic_count_after_push", 32'(count), 32'd1);
    checkOutput("basic_no_upd_yet", 32'(upd_valid), 32'd0);
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("basic_upd_valid", 32'(upd_valid), 32'd1);
    checkOutput("basic_upd_index", 32'(upd_index), 32'h155);
    checkOutput("basic_local_correct", 32'(upd_local_correct), 32'd1);
    checkOutput("basic_global_correct", 32'(upd_global_correct), 32'd0);
    checkOutput("basic_mispredict", 32'(mispredict), 32'd1);
    checkOutput("basic_count_after_pop", 32'(count), 32'd0);
    idleCycle();
    checkOutput("basic_upd_pulse_end", 32'(upd_valid), 32'd0);
    checkOutput("basic_mispredict_qual", 32'(mispredict), 32'd0);
    checkOutput("basic_index_holds", 32'(upd_index), 32'h155);

    // Fill to DEPTH, overflow push, then drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fill_idx[i], fill_lp[i], fill_gp[i], fill_ch[i], 1'b0, 1'b0, 1'b0);
    end
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_push_ready", 32'(push_ready), 32'd0);
    checkOutput("full_err_clear", 32'(err), 32'd0);
    applyStimulus(1'b1, 10'h055, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("overflow_count", 32'(count), 32'd4);
    checkOutput("overflow_err", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, fill_tk[i], 1'b0);
      checkOutput($sformatf("drain%0d_valid", i), 32'(upd_valid), 32'd1);
      checkOutput($sformatf("drain%0d_index", i), 32'(upd_index), 32'(fill_idx[i]));
      checkOutput($sformatf("drain%0d_lc", i), 32'(upd_local_correct), 32'(fill_lc[i]));
      checkOutput($sformatf("drain%0d_gc", i), 32'(upd_global_correct), 32'(fill_gc[i]));
      checkOutput($sformatf("drain%0d_mp", i), 32'(mispredict), 32'(fill_mp[i]));
    end
    checkOutput("drain_count", 32'(count), 32'd0);

    // Simultaneous push and resolve at count 2
    applyStimulus(1'b1, 10'h0A1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h0B2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("simul_pre_count", 32'(count), 32'd2);
    applyStimulus(1'b1, 10'h0C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("simul_count", 32'(count), 32'd2);
    checkOutput("simul_upd_valid", 32'(upd_valid), 32'd1);
    checkOutput("simul_upd_index", 32'(upd_index), 32'h0A1);
    idleCycle();
    checkOutput("simul_single_pulse", 32'(upd_valid), 32'd0);

    // Flush at count 3 overrides same-cycle push and resolve
    applyStimulus(1'b1, 10'h0D4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_pre_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 10'h0E5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_no_upd", 32'(upd_valid), 32'd0);
    checkOutput("flush_push_ready", 32'(push_ready), 32'd1);

    // Asynchronous reset mid-stream with an entry in flight and a pulse active
    applyStimulus(1'b1, 10'h1E1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h1F2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_pre_valid", 32'(upd_valid), 32'd1);
    checkOutput("midrst_pre_count", 32'(count), 32'd1);
    resolve_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_upd_valid", 32'(upd_valid), 32'd0);
    checkOutput("midrst_upd_index", 32'(upd_index), 32'd0);
    checkOutput("midrst_lc", 32'(upd_local_correct), 32'd0);
    checkOutput("midrst_gc", 32'(upd_global_correct), 32'd0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_push_ready", 32'(push_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Resolve on empty (the pre-reset entry must be gone)
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("empty_resolve_no_upd", 32'(upd_valid), 32'd0);
    checkOutput("empty_resolve_err", 32'(err), 32'd1);
    checkOutput("empty_resolve_count", 32'(count), 32'd0);
    idleCycle();
    checkOutput("err_sticky", 32'(err), 32'd1);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Ten overlapped push/resolve cycles wrap both pointers
    applyStimulus(1'b1, 10'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 10'(10'h101 + k), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("wrap%0d_valid", k), 32'(upd_valid), 32'd1);
      checkOutput($sformatf("wrap%0d_index", k), 32'(upd_index), 32'(10'h100 + k));
      checkOutput($sformatf("wrap%0d_count", k), 32'(count), 32'd1);
    end
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_last_index", 32'(upd_index), 32'h10A);
    checkOutput("wrap_last_lc", 32'(upd_local_correct), 32'd1);
    checkOutput("wrap_last_gc", 32'(upd_global_correct), 32'd0);
    checkOutput("wrap_last_mp", 32'(mispredict), 32'd0);
    checkOutput("wrap_count", 32'(count), 32'd0);
    checkOutput("wrap_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
